// File: rtl/unary_stream_gen.sv
// Serialises two binary operands into fixed-length thermometer-coded streams
// and sequences the downstream unary adder through its read and write phases.
module unary_stream_gen #(
  parameter int LEN       = 15,
  parameter int W         = 4,
  parameter int DRAIN_LEN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] val_a,
  input  logic [W-1:0] val_b,
  output logic         ready,
  output logic         a_out,
  output logic         b_out,
  output logic         add_en,
  output logic         rw_sel,
  output logic         done
);

  // Counter must hold both the stream index and the drain index without wrapping.
  localparam int CW = ((W + 1) > $clog2(DRAIN_LEN + 1)) ? (W + 1) : $clog2(DRAIN_LEN + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] k;
  logic [CW-1:0] k_next;
  logic [CW-1:0] op_a;
  logic [CW-1:0] op_b;

  function automatic logic [CW-1:0] clamp(input logic [W-1:0] v);
    logic [CW-1:0] wide;
    wide = CW'(v);
    return (wide > CW'(LEN)) ? CW'(LEN) : wide;
  endfunction

  assign k_next = k + CW'(1);

  // Outputs are computed for the state being entered so they appear registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      op_a   <= '0;
      op_b   <= '0;
      ready  <= 1'b1;
      a_out  <= 1'b0;
      b_out  <= 1'b0;
      add_en <= 1'b0;
      rw_sel <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= STREAM;
            k      <= '0;
            op_a   <= clamp(val_a);
            op_b   <= clamp(val_b);
            ready  <= 1'b0;
            a_out  <= (clamp(val_a) != '0);
            b_out  <= (clamp(val_b) != '0);
            add_en <= 1'b1;
            rw_sel <= 1'b0;
          end
        end
        STREAM: begin
          if (k == CW'(LEN - 1)) begin
            state  <= DRAIN;
            k      <= '0;
            a_out  <= 1'b0;
            b_out  <= 1'b0;
            rw_sel <= 1'b1;
          end else begin
            k     <= k_next;
            a_out <= (k_next < op_a);
            b_out <= (k_next < op_b);
          end
        end
        DRAIN: begin
          if (k == CW'(DRAIN_LEN - 1)) begin
            state  <= DONE;
            k      <= '0;
            add_en <= 1'b0;
            rw_sel <= 1'b0;
            done   <= 1'b1;
          end else begin
            k <= k_next;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
